// File: rtl/lb_row_sched.sv
// Row scheduler for the 3x3 convolution front end: steers the pixel-word stream
// into three rotating line buffers and flags when a full 3-row window is resident.
module lb_row_sched #(
    parameter int DATA_W = 32,
    parameter int WORDS  = 25,
    parameter int ROWS   = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [2:0]        lb_wr_en,
    output logic [DATA_W-1:0] lb_wr_data,
    output logic [1:0]        top,
    output logic              data_valid,
    input  logic              cons_done,
    output logic              frame_done
);

    localparam int WC_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(WORDS - 1);
    localparam logic [RC_W-1:0] ROW_END   = RC_W'(ROWS - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        WAIT  = 2'd2,
        FILL  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [WC_W-1:0]   word_cnt;
    logic [1:0]        line_cnt;
    logic [RC_W-1:0]   row_cnt;
    logic [RC_W-1:0]   row_cnt_inc;
    logic [1:0]        top_q;
    logic              accept;
    logic              word_last;
    logic              line_last;
    logic              row_end;
    logic              cons_take;

    logic [2:0]        wr_en_p1;
    logic [DATA_W-1:0] wr_data_p1;
    logic              win_done_p1;
    logic              data_valid_q;
    logic              frame_done_q;

    assign accept      = in_valid && in_ready;
    assign word_last   = (word_cnt == WORD_LAST);
    assign line_last   = (line_cnt == 2'd2);
    assign row_cnt_inc = row_cnt + 1'b1;
    assign row_end     = (row_cnt_inc == ROW_END);
    assign cons_take   = (state == WAIT) && cons_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = PRIME;
            end
            PRIME: begin
                in_ready = 1'b1;
                if (accept && word_last && line_last) state_nxt = WAIT;
            end
            WAIT: begin
                if (cons_done) state_nxt = row_end ? IDLE : FILL;
            end
            FILL: begin
                in_ready = 1'b1;
                if (accept && word_last) state_nxt = WAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Position counters; FILL reuses word_cnt and retires the oldest row by rotating top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            line_cnt <= 2'd0;
            row_cnt  <= '0;
            top_q    <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        word_cnt <= '0;
                        line_cnt <= 2'd0;
                        row_cnt  <= '0;
                        top_q    <= 2'd0;
                    end
                end
                PRIME: begin
                    if (accept) begin
                        if (word_last) begin
                            word_cnt <= '0;
                            line_cnt <= line_last ? 2'd0 : line_cnt + 2'd1;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cons_done) row_cnt <= row_cnt_inc;
                end
                FILL: begin
                    if (accept) begin
                        if (word_last) begin
                            word_cnt <= '0;
                            top_q    <= (top_q == 2'd2) ? 2'd0 : top_q + 2'd1;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: registered write strobe and data, one cycle after acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_p1    <= 3'b000;
            wr_data_p1  <= '0;
            win_done_p1 <= 1'b0;
        end else begin
            wr_en_p1    <= 3'b000;
            win_done_p1 <= accept && word_last && ((state == FILL) || line_last);
            if (accept) begin
                wr_en_p1   <= (state == FILL) ? (3'b001 << top_q) : (3'b001 << line_cnt);
                wr_data_p1 <= in_data;
            end
        end
    end

    // Stage p2: window flagged only after its last strobe has landed in the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= cons_take && row_end;
            if (cons_take) begin
                data_valid_q <= 1'b0;
            end else if (win_done_p1) begin
                data_valid_q <= 1'b1;
            end
        end
    end

    assign lb_wr_en   = wr_en_p1;
    assign lb_wr_data = wr_data_p1;
    assign top        = top_q;
    assign data_valid = data_valid_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lb_row_sched.sv
// Directed bench for lb_row_sched with WORDS=4, ROWS=5: reset, priming,
// rotation, frame end, backpressure and ignored controls.
module tb_lb_row_sched;

    localparam int DATA_W = 32;
    localparam int WORDS  = 4;
    localparam int ROWS   = 5;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [2:0]        lb_wr_en;
    logic [DATA_W-1:0] lb_wr_data;
    logic [1:0]        top;
    logic              data_valid;
    logic              cons_done;
    logic              frame_done;

    int checks   = 0;
    int failures = 0;

    lb_row_sched #(
        .DATA_W(DATA_W),
        .WORDS (WORDS),
        .ROWS  (ROWS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .lb_wr_en  (lb_wr_en),
        .lb_wr_data(lb_wr_data),
        .top       (top),
        .data_valid(data_valid),
        .cons_done (cons_done),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic rdy, input logic [2:0] en,
                           input logic [31:0] dat, input logic [1:0] tp,
                           input logic dv, input logic fd);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".lb_wr_en"}, 32'(lb_wr_en), 32'(en));
        if (en != 3'b000) chk({tag, ".lb_wr_data"}, lb_wr_data, dat);
        chk({tag, ".top"}, 32'(top), 32'(tp));
        chk({tag, ".data_valid"}, 32'(data_valid), 32'(dv));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(fd));
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        cons_done = 1'b0;
        tick();
        tick();
        chk_all("reset", 1'b0, 3'b000, 32'd0, 2'd0, 1'b0, 1'b0);
        chk("reset.lb_wr_data", lb_wr_data, 32'd0);
        rst = 1'b0;

        // Idle: in_valid without start writes nothing
        in_valid = 1'b1;
        in_data  = 32'hAA;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("idle", 1'b0, 3'b000, 32'd0, 2'd0, 1'b0, 1'b0);
        end

        // Start, accept two words, then reset mid-PRIME with in_valid still high
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start.in_ready", 32'(in_ready), 32'd1);
        in_data = 32'h55;
        tick();
        chk_all("pre_rst_w0", 1'b1, 3'b001, 32'h55, 2'd0, 1'b0, 1'b0);
        in_data = 32'h56;
        #2;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 3'b000, 32'd0, 2'd0, 1'b0, 1'b0);
        chk("async_rst.lb_wr_data", lb_wr_data, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk_all("post_rst", 1'b0, 3'b000, 32'd0, 2'd0, 1'b0, 1'b0);

        // Prime with a gap after word 1 and a stray cons_done during word 5
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("prime.in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = 32'd1;
        tick();
        chk_all("prime_w1", 1'b1, 3'b001, 32'd1, 2'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        in_data  = 32'hDEAD;
        tick();
        chk_all("prime_gap", 1'b1, 3'b000, 32'd0, 2'd0, 1'b0, 1'b0);
        in_valid = 1'b1;
        for (int w = 2; w <= 12; w++) begin
            in_data   = 32'(w);
            cons_done = (w == 5);
            tick();
            cons_done = 1'b0;
            chk_all($sformatf("prime_w%0d", w), (w != 12), 3'b001 << ((w - 1) / WORDS),
                    32'(w), 2'd0, 1'b0, 1'b0);
        end

        // WAIT with in_valid held: no strobe, word not consumed; start ignored
        in_data = 32'd13;
        tick();
        chk_all("wait_dv", 1'b0, 3'b000, 32'd0, 2'd0, 1'b1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_all("wait_start_ign", 1'b0, 3'b000, 32'd0, 2'd0, 1'b1, 1'b0);

        // First cons_done: FILL buffer 0 with 13..16, then top=1
        cons_done = 1'b1;
        tick();
        cons_done = 1'b0;
        chk_all("cons1", 1'b1, 3'b000, 32'd0, 2'd0, 1'b0, 1'b0);
        for (int w = 13; w <= 16; w++) begin
            in_data = 32'(w);
            tick();
            chk_all($sformatf("fill1_w%0d", w), (w != 16), 3'b001, 32'(w),
                    (w == 16) ? 2'd1 : 2'd0, 1'b0, 1'b0);
        end
        in_data = 32'd17;
        tick();
        chk_all("fill1_dv", 1'b0, 3'b000, 32'd0, 2'd1, 1'b1, 1'b0);

        // Second cons_done together with start: start ignored, FILL buffer 1
        cons_done = 1'b1;
        start     = 1'b1;
        tick();
        cons_done = 1'b0;
        start     = 1'b0;
        chk_all("cons2", 1'b1, 3'b000, 32'd0, 2'd1, 1'b0, 1'b0);
        for (int w = 17; w <= 20; w++) begin
            in_data = 32'(w);
            tick();
            chk_all($sformatf("fill2_w%0d", w), (w != 20), 3'b010, 32'(w),
                    (w == 20) ? 2'd2 : 2'd1, 1'b0, 1'b0);
        end
        in_data = 32'd21;
        tick();
        chk_all("fill2_dv", 1'b0, 3'b000, 32'd0, 2'd2, 1'b1, 1'b0);

        // Third cons_done ends the frame
        cons_done = 1'b1;
        tick();
        cons_done = 1'b0;
        chk_all("frame_end", 1'b0, 3'b000, 32'd0, 2'd2, 1'b0, 1'b1);
        tick();
        chk_all("frame_end_p1", 1'b0, 3'b000, 32'd0, 2'd2, 1'b0, 1'b0);
        tick();
        chk_all("idle_after", 1'b0, 3'b000, 32'd0, 2'd2, 1'b0, 1'b0);
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lb_row_sched.md
# lb_row_sched

Row scheduler for the 3x3 convolution front end. Accepts the incoming pixel-word stream, routes it one line at a time into three rotating line buffers, and tells the window engine when a 3-row window is resident. After every completed output row it refills only the oldest buffer and rotates the top-row pointer. It replaces ad-hoc write steering with one state machine that owns every line-buffer write strobe.

## Interface
- DATA_W, 32: pixel-word width.
- WORDS, 25: words per image line, at least 2.
- ROWS, 25: image lines per frame, at least 3.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  frame start pulse; honoured only in IDLE.
- in_valid  in  1  input word valid.
- in_data  in  DATA_W  input word.
- in_ready  out  1  scheduler can take a word; combinational from state.
- lb_wr_en  out  3  one-hot write strobe per line buffer (bit i targets buffer i); registered.
- lb_wr_data  out  DATA_W  registered copy of the accepted word.
- top  out  2  index 0..2 of the buffer holding the topmost window row.
- data_valid  out  1  level; a full 3-row window is resident.
- cons_done  in  1  pulse from the window engine; the current output row is finished.
- frame_done  out  1  one-cycle pulse; the frame is complete.

## Operation
- States: IDLE, PRIME, WAIT, FILL.
- in_ready is 1 only in PRIME or FILL. A word is accepted when in_valid and in_ready are both 1.
- IDLE:
  - On start, clear the counters, set top=0, go to PRIME.
  - start in any other state is ignored.
- PRIME fills buffers 0, 1, 2 in order, WORDS accepted words each.
  - word_cnt counts 0..WORDS-1 and wraps to 0 at the end of a line.
  - line_cnt counts 0..2 and selects the target buffer.
  - Acceptance of word WORDS-1 of line 2 moves to WAIT.
- WAIT holds in_ready at 0.
  - On cons_done: row_cnt increments and data_valid clears.
  - If the new row_cnt equals ROWS-2, pulse frame_done and go to IDLE.
  - Otherwise go to FILL.
- FILL writes WORDS words into buffer `top`, which holds the oldest row.
  - On acceptance of the last word, set top=(top+1) mod 3 and go to WAIT.
- Write path: each accepted word drives the selected lb_wr_en bit and lb_wr_data on the next cycle. Without an acceptance, lb_wr_en is 0.
- cons_done outside WAIT is ignored. in_valid while in_ready=0 is ignored, and the word is not consumed.
- Counter widths: word_cnt is clog2(WORDS) bits; row_cnt is clog2(ROWS) bits. No counter exceeds its terminal value.
- frame_done is emitted exactly once per frame, after ROWS-2 cons_done pulses.

## Timing
- Reset values: in_ready=0, lb_wr_en=0, lb_wr_data=0, top=0, data_valid=0, frame_done=0, state=IDLE, all counters 0.
- Reset mid-frame aborts immediately. Write strobes drop asynchronously and no further word is accepted.
- start at cycle T: in_ready=1 from T+1.
- Write latency: a word accepted at edge N gives lb_wr_en/lb_wr_data valid during cycle N+1. Back-to-back acceptance gives back-to-back strobes.
- data_valid rises at N+2 after the last word of a window fill is accepted at edge N. This is one cycle after its write strobe, so the buffer holds the line.
- The new top value appears together with the final FILL strobe, at N+1.
- cons_done sampled at edge M:
  - data_valid=0 from M+1.
  - in_ready=1 from M+1 (FILL), or frame_done=1 for cycle M+1 only (last row).
- start and cons_done arriving together in WAIT: cons_done is processed, start is ignored.
- Throughput: 1 word per cycle while in_valid=1. Per output row, the stall is WORDS cycles of FILL plus the consumer time.

## Test plan
- Reset/idle: assert rst mid-PRIME with in_valid=1 -> all outputs at reset values within the reset cycle. After release, no strobes until start.
- Prime (WORDS=4, ROWS=5, continuous in_valid, data 1..12):
  - lb_wr_en = 001 x4, 010 x4, 100 x4 with lb_wr_data=1..12.
  - data_valid high 2 cycles after word 12 is accepted.
  - in_ready low after word 12.
- Rotation (same setup): cons_done.
  - Words 13..16 go to buffer 0, then top=1.
  - Second cons_done: words 17..20 go to buffer 1, then top=2.
- Frame end (same setup): third cons_done -> frame_done=1 for exactly one cycle, state IDLE, in_ready=0, no write strobe.
- Backpressure and ignores:
  - in_valid toggling 1,0,1 in PRIME -> strobes only for the valid cycles; word_cnt unaffected by gaps.
  - cons_done in PRIME and start in WAIT -> no effect.
- Stalled input: in_valid held at 1 while in WAIT -> no strobe, no word consumed. The first FILL strobe carries the word presented at the first in_ready=1 cycle.
